float_delay: RTL and testbench
==============================

# float_delay

Upstream neighbour of the floating multiply-accumulate stage in the ADPCM predictor path. The block converts each new quantized difference DQ and reconstructed signal SR into the 11-bit predictor floating format. It maintains the six-tap DQ delay line and the two-tap SR delay line, and presents all eight floating operands as one registered, handshaked word to the multiply-accumulate stage.

## Interface
Parameters:
- NDQ, 6, number of DQ delay taps.
- NSR, 2, number of SR delay taps.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous delay-line reinitialise (rate change); active-high.
- in_valid  in  1  new sample present on dq/sr.
- in_ready  out  1  block can accept a sample this cycle.
- dq  in  15  sign-magnitude difference: [14] sign, [13:0] magnitude.
- sr  in  16  two's-complement reconstructed signal.
- out_valid  out  1  operand word valid.
- out_ready  in  1  consumer takes operand word.
- dq_flt  out  66  DQ1..DQ6 floats; DQ1 at [10:0], DQk at [11k-1:11k-11].
- sr_flt  out  22  SR1 at [10:0], SR2 at [21:11].

## Operation
- Float format, 11 bits: [10] sign, [9:6] exponent, [5:0] mantissa.
- Conversion of magnitude M:
  - EXP = bit-length of M, i.e. index of the leading one plus 1, or 0 if M = 0.
  - MANT = 32 if M = 0, else ((M << 6) >> EXP) truncated to 6 bits. MANT[5] is always 1.
- DQ conversion: sign = dq[14], M = dq[13:0], so EXP is 0..14.
- SR conversion: sign = sr[15], M = |sr|.
  - sr = -32768 saturates M to 32767.
  - EXP is 0..15.
- Init value of every tap is 11'h020 (+, exp 0, mant 32).
- Accept condition: in_valid && in_ready.
  - Each tap shifts by one: DQk <= DQk-1 for k = 2..6, DQ1 <= float(dq).
  - SR2 <= SR1, SR1 <= float(sr).
- State machine, 2 states:
  - EMPTY: out_valid = 0. On accept, go to FULL.
  - FULL: out_valid = 1.
    - On out_ready without a new accept, go to EMPTY.
    - On out_ready with a simultaneous accept, stay in FULL with the new taps.
- in_ready = !out_valid || out_ready. This is a single-entry buffer with same-cycle replace.
- While out_valid = 1 and out_ready = 0, dq_flt and sr_flt are held stable and no shift occurs.
- clear:
  - Next edge: all taps go to 11'h020 and state goes to EMPTY.
  - clear overrides a simultaneous accept; that sample is discarded.
  - clear overrides a pending out_valid; the word is dropped.
  - in_ready is forced to 0 during the clear cycle.
- reset, asynchronous and at any time including mid-handshake:
  - taps = 11'h020, state = EMPTY, out_valid = 0.
  - in_ready = 1 once reset is released.

## Timing
- Latency: sample accepted at edge N, so out_valid = 1 and the new taps are visible after edge N.
- Throughput: one sample per cycle when out_ready is held high.
- All outputs are registered except in_ready, which is combinational from out_valid, out_ready and clear.
- Reset values:
  - out_valid = 0.
  - dq_flt = {6{11'h020}}.
  - sr_flt = {2{11'h020}}.
  - in_ready = 1 when clear = 0.
- There is no combinational path from dq/sr to any output.

## Structure
- Shared package `adpcm_pkg` holds:
  - FLT_W = 11, EXP_W = 4, MANT_W = 6.
  - FLT_INIT = 11'h020.
  - a float_t packed struct {sign, exp, mant}.
  - the state enum {EMPTY, FULL}.
- Sub-module `float_conv`, parameterised on magnitude width:
  - a combinational leading-one detector plus normalising shift.
  - instantiated twice: MAG_W = 14 for DQ, MAG_W = 15 for SR.
  - SR saturation and absolute value are done in the parent.
- Top level holds the tap registers, the FSM and the handshake logic.

## Test plan
- Reset then idle: dq_flt = {6{11'h020}}, sr_flt = {2{11'h020}}, out_valid = 0, in_ready = 1.
- Single accept with dq = 15'h0064 and sr = 16'hFF9C (-100):
  - DQ1 = 11'h1F2 (+, exp 7, mant 50).
  - SR1 = 11'h5F2 (-, exp 7, mant 50).
  - out_valid = 1 one cycle later.
- Boundary conversions:
  - dq = 0 and dq = 1 both give exp 0/1 respectively with mant 32.
  - dq = 15'h3FFF gives 11'h3BF.
  - sr = 16'h8000 saturates, giving 11'h7FF.
  - sr = 16'h7FFF gives 11'h3FF.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1.
  - Only one sample is accepted.
  - in_ready = 0 and outputs are stable.
  - Releasing out_ready accepts the next sample in the same cycle.
- Streaming: 8 back-to-back samples dq = 1..8 with out_ready = 1.
  - After the 8th, DQ1..DQ6 = float(8)..float(3).
  - SR2 holds the 7th SR.
- clear asserted together with in_valid while out_valid = 1:
  - Next cycle all taps = 11'h020 and out_valid = 0.
  - The sample is not captured.
- Async reset pulse mid-stream, between clock edges: outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/adpcm_pkg.sv
// Shared types and constants for the ADPCM predictor floating-point path.
// The 11-bit float is {sign, 4-bit exponent, 6-bit mantissa}.
package adpcm_pkg;

    localparam int FLT_W  = 11;
    localparam int EXP_W  = 4;
    localparam int MANT_W = 6;

    localparam logic [FLT_W-1:0] FLT_INIT = 11'h020;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float_t;

    typedef enum logic {
        EMPTY,
        FULL
    } state_e;

endpackage

// File: rtl/float_conv.sv
// Magnitude-to-float converter: leading-one detect gives the exponent, then
// the magnitude is normalised so its leading one lands in the mantissa MSB.
module float_conv
    import adpcm_pkg::*;
#(
    parameter int MAG_W = 14
) (
    input  logic [MAG_W-1:0]  mag_i,
    output logic [EXP_W-1:0]  exp_o,
    output logic [MANT_W-1:0] mant_o
);

    logic [MAG_W+MANT_W-1:0] normalised;

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        exp_o = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (mag_i[i]) begin
                exp_o = EXP_W'(i + 1);
            end
        end
    end

    assign normalised = {mag_i, {MANT_W{1'b0}}} >> exp_o;
    assign mant_o     = (exp_o == '0) ? MANT_W'(32) : normalised[MANT_W-1:0];

endmodule

// File: rtl/float_delay.sv
// DQ/SR float delay lines feeding the predictor multiply-accumulate stage,
// presented as one registered word behind a single-entry valid/ready buffer.
module float_delay
    import adpcm_pkg::*;
#(
    parameter int NDQ = 6,
    parameter int NSR = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [14:0]            dq,
    input  logic [15:0]            sr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLT_W*NDQ-1:0]   dq_flt,
    output logic [FLT_W*NSR-1:0]   sr_flt
);

    state_e state_q, state_d;
    float_t dqTaps_q [NDQ];
    float_t dqTaps_d [NDQ];
    float_t srTaps_q [NSR];
    float_t srTaps_d [NSR];

    logic              accept;
    logic [15:0]       srNeg;
    logic [14:0]       srMag;
    logic [EXP_W-1:0]  dqExp, srExp;
    logic [MANT_W-1:0] dqMant, srMant;
    float_t            dqNew, srNew;

    // -32768 has no positive 16-bit counterpart, so it saturates to 32767.
    assign srNeg = -sr;
    assign srMag = !sr[15]          ? sr[14:0] :
                   (sr == 16'h8000) ? 15'h7FFF : srNeg[14:0];

    float_conv #(.MAG_W(14)) dqConv (
        .mag_i  (dq[13:0]),
        .exp_o  (dqExp),
        .mant_o (dqMant)
    );

    float_conv #(.MAG_W(15)) srConv (
        .mag_i  (srMag),
        .exp_o  (srExp),
        .mant_o (srMant)
    );

    assign dqNew = '{sign: dq[14], exp: dqExp, mant: dqMant};
    assign srNew = '{sign: sr[15], exp: srExp, mant: srMant};

    assign out_valid = (state_q == FULL);
    assign in_ready  = (!out_valid || out_ready) && !clear;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    // Clear reinitialises the lines; accept is already blocked while clear is high.
    always_comb begin
        dqTaps_d = dqTaps_q;
        srTaps_d = srTaps_q;
        if (clear) begin
            for (int k = 0; k < NDQ; k++) dqTaps_d[k] = float_t'(FLT_INIT);
            for (int k = 0; k < NSR; k++) srTaps_d[k] = float_t'(FLT_INIT);
        end else if (accept) begin
            for (int k = 1; k < NDQ; k++) dqTaps_d[k] = dqTaps_q[k-1];
            for (int k = 1; k < NSR; k++) srTaps_d[k] = srTaps_q[k-1];
            dqTaps_d[0] = dqNew;
            srTaps_d[0] = srNew;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            for (int k = 0; k < NDQ; k++) dqTaps_q[k] <= float_t'(FLT_INIT);
            for (int k = 0; k < NSR; k++) srTaps_q[k] <= float_t'(FLT_INIT);
        end else begin
            state_q  <= state_d;
            dqTaps_q <= dqTaps_d;
            srTaps_q <= srTaps_d;
        end
    end

    always_comb begin
        dq_flt = '0;
        sr_flt = '0;
        for (int k = 0; k < NDQ; k++) dq_flt[k*FLT_W +: FLT_W] = dqTaps_q[k];
        for (int k = 0; k < NSR; k++) sr_flt[k*FLT_W +: FLT_W] = srTaps_q[k];
    end

endmodule

// File: tb/tb_float_delay.sv
// Directed bench for float_delay: conversion table, shift behaviour,
// backpressure, clear and asynchronous reset.
module tb_float_delay;

    typedef struct {
        logic [14:0] dq;
        logic [15:0] sr;
        logic [10:0] expDq;
        logic [10:0] expSr;
    } vector_t;

    localparam logic [65:0] DQ_INIT = {6{11'h020}};
    localparam logic [21:0] SR_INIT = {2{11'h020}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [14:0] dq = '0;
    logic [15:0] sr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [65:0] dq_flt;
    logic [21:0] sr_flt;

    int checks = 0;
    int failures = 0;

    vector_t     vectors [6];
    logic [10:0] streamFlt [8];

    float_delay #(.NDQ(6), .NSR(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dq        (dq),
        .sr        (sr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dq_flt    (dq_flt),
        .sr_flt    (sr_flt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [87:0] actual, input logic [87:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic ordy, input logic clr,
                                 input logic [14:0] d, input logic [15:0] s);
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        clear     = clr;
        dq        = d;
        sr        = s;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [10:0] prevDq;

        vectors[0] = '{15'h0064, 16'hFF9C, 11'h1F2, 11'h5F2};
        vectors[1] = '{15'h0000, 16'h0000, 11'h020, 11'h020};
        vectors[2] = '{15'h0001, 16'h0001, 11'h060, 11'h060};
        vectors[3] = '{15'h3FFF, 16'h7FFF, 11'h3BF, 11'h3FF};
        vectors[4] = '{15'h0000, 16'h8000, 11'h020, 11'h7FF};
        vectors[5] = '{15'h4064, 16'h0064, 11'h5F2, 11'h1F2};

        streamFlt = '{11'h060, 11'h0A0, 11'h0B0, 11'h0E0, 11'h0E8, 11'h0F0, 11'h0F8, 11'h120};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset dq_flt", 88'(dq_flt), 88'(DQ_INIT));
        checkOutput("reset sr_flt", 88'(sr_flt), 88'(SR_INIT));
        checkOutput("reset out_valid", 88'(out_valid), 88'd0);
        checkOutput("reset in_ready", 88'(in_ready), 88'd1);

        // Conversion table, one accept per cycle; DQ2 must hold the previous DQ1.
        prevDq = 11'h020;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, vectors[i].dq, vectors[i].sr);
            tick();
            checkOutput($sformatf("vec%0d DQ1", i), 88'(dq_flt[10:0]), 88'(vectors[i].expDq));
            checkOutput($sformatf("vec%0d SR1", i), 88'(sr_flt[10:0]), 88'(vectors[i].expSr));
            checkOutput($sformatf("vec%0d DQ2", i), 88'(dq_flt[21:11]), 88'(prevDq));
            checkOutput($sformatf("vec%0d out_valid", i), 88'(out_valid), 88'd1);
            prevDq = vectors[i].expDq;
        end

        applyStimulus(1'b0, 1'b1, 1'b0, 15'h0, 16'h0);
        tick();
        checkOutput("drain out_valid", 88'(out_valid), 88'd0);
        checkOutput("drain in_ready", 88'(in_ready), 88'd1);

        // Backpressure: five cycles of in_valid with out_ready low.
        applyStimulus(1'b1, 1'b0, 1'b0, 15'h0002, 16'h0002);
        tick();
        checkOutput("bp first out_valid", 88'(out_valid), 88'd1);
        checkOutput("bp first DQ1", 88'(dq_flt[10:0]), 88'h0A0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 15'(15'h3FFF - c), 16'(16'h7000 + c));
            checkOutput($sformatf("bp%0d in_ready", c), 88'(in_ready), 88'd0);
            tick();
            checkOutput($sformatf("bp%0d DQ1", c), 88'(dq_flt[10:0]), 88'h0A0);
            checkOutput($sformatf("bp%0d SR1", c), 88'(sr_flt[10:0]), 88'h0A0);
            checkOutput($sformatf("bp%0d out_valid", c), 88'(out_valid), 88'd1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 15'h0003, 16'h0003);
        checkOutput("bp release in_ready", 88'(in_ready), 88'd1);
        tick();
        checkOutput("bp release DQ1", 88'(dq_flt[10:0]), 88'h0B0);
        checkOutput("bp release DQ2", 88'(dq_flt[21:11]), 88'h0A0);
        checkOutput("bp release out_valid", 88'(out_valid), 88'd1);

        applyStimulus(1'b0, 1'b0, 1'b1, 15'h0, 16'h0);
        checkOutput("clear in_ready", 88'(in_ready), 88'd0);
        tick();
        checkOutput("clear dq_flt", 88'(dq_flt), 88'(DQ_INIT));
        checkOutput("clear out_valid", 88'(out_valid), 88'd0);

        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 15'(k), 16'(k));
            tick();
        end
        checkOutput("stream dq_flt", 88'(dq_flt),
                    88'({streamFlt[2], streamFlt[3], streamFlt[4], streamFlt[5], streamFlt[6], streamFlt[7]}));
        checkOutput("stream sr_flt", 88'(sr_flt), 88'({streamFlt[6], streamFlt[7]}));
        checkOutput("stream out_valid", 88'(out_valid), 88'd1);

        // Clear with a held word and a competing sample: both are dropped.
        applyStimulus(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
        tick();
        checkOutput("held out_valid", 88'(out_valid), 88'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 15'h0005, 16'h0005);
        checkOutput("clear+valid in_ready", 88'(in_ready), 88'd0);
        tick();
        checkOutput("clear+valid dq_flt", 88'(dq_flt), 88'(DQ_INIT));
        checkOutput("clear+valid sr_flt", 88'(sr_flt), 88'(SR_INIT));
        checkOutput("clear+valid out_valid", 88'(out_valid), 88'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
        checkOutput("post clear in_ready", 88'(in_ready), 88'd1);

        // Asynchronous reset landing between clock edges.
        applyStimulus(1'b1, 1'b1, 1'b0, 15'h0064, 16'hFF9C);
        @(posedge clk);
        #3;
        checkOutput("pre reset DQ1", 88'(dq_flt[10:0]), 88'h1F2);
        reset = 1'b1;
        #1;
        checkOutput("async reset dq_flt", 88'(dq_flt), 88'(DQ_INIT));
        checkOutput("async reset sr_flt", 88'(sr_flt), 88'(SR_INIT));
        checkOutput("async reset out_valid", 88'(out_valid), 88'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("after reset in_ready", 88'(in_ready), 88'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 15'h0001, 16'h0001);
        tick();
        checkOutput("after reset DQ1", 88'(dq_flt[10:0]), 88'h060);
        checkOutput("after reset DQ2", 88'(dq_flt[21:11]), 88'h020);
        checkOutput("after reset out_valid", 88'(out_valid), 88'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
